mtm_alu_deserializer: RTL and testbench
=======================================

// Module: mtm_alu_deserializer
// PURPOSE
//   Receive side of the ALU serial input link. Deframes 11-bit packets from sin.
//   Collects operands A and B plus the command packet, and checks packet count, CRC4 and opcode.
//   Presents one decoded operation per frame to the ALU core with a single-cycle valid strobe.
//   Sits between the sin pin and the ALU datapath; no backpressure.
// PARAMETERS
//   DATA_PKTS  8   data packets per valid frame (4 for A, then 4 for B, MSB byte first)
//   CRC_W      4   CRC width; polynomial x^4+x+1, init 0 (fixed for DATA_PKTS=8)
// PORTS
//   clk        in   1   clock; sin sampled on posedge, one bit per cycle
//   rst        in   1   synchronous, active-high reset
//   sin        in   1   serial input; idles high
//   out_valid  out  1   one-cycle strobe: frame complete, outputs below valid
//   out_a      out  32  operand A
//   out_b      out  32  operand B
//   out_op     out  3   opcode from command packet
//   err_data   out  1   wrong data-packet count or framing error
//   err_crc    out  1   CRC mismatch
//   err_op     out  1   opcode not in {000 AND, 001 OR, 100 ADD, 101 SUB}
// BEHAVIOUR
//   Reset: all outputs 0, FSM IDLE, packet count 0, CRC register 0. Takes effect the cycle
//     rst is sampled high, including mid-packet; partial frame discarded.
//   Packet, first bit on wire first: start(0), type(0=data,1=cmd), payload[7:0] MSB first, stop(1).
//   FSM states:
//     IDLE: sin=1 stays; sin=0 -> TYPE.
//     TYPE: latch type bit -> PAYLOAD, bit counter 0.
//     PAYLOAD: 8 cycles shift payload. Data packet also shifts each bit into CRC LFSR.
//       After the 8th bit -> STOP.
//     STOP: sin=1 -> packet accepted -> IDLE.
//       sin=0 -> framing error: out_valid=1 with err_data=1 next cycle, frame cleared -> IDLE.
//   Back-to-back packets: a start bit in the cycle right after a stop bit must be accepted
//     (STOP returns to IDLE combinationally-equivalent, i.e. no dead cycle).
//   Data packet accepted: payload shifted into 64-bit {A,B} register.
//     Count increments, saturating at 15. Extra bytes shift through and are not stored separately.
//   Cmd packet accepted: payload = {x, op[2:0], crc[3:0]}.
//     CRC covers the 68-bit vector {A,B,1'b1,op}, MSB first.
//     The constant 1 and op are fed after the data bytes.
//       The constant 1 replaces payload bit7; payload bit7 value is ignored.
//     LFSR step per bit d: fb = crc[3]^d; crc = {crc[2:0],1'b0} ^ (fb ? 4'b0011 : 0).
//   Result strobe: out_valid asserted exactly one cycle, in the cycle after the cmd stop bit is
//     sampled. out_a/out_b/out_op/err_* update in that same cycle and hold until the next strobe.
//   Error priority: err_data (count != DATA_PKTS) suppresses crc/op checks, so err_crc=err_op=0.
//     Otherwise err_crc and err_op are evaluated independently; both may be 1.
//   On err_data, out_a/out_b/out_op are 0.
//   After any strobe: count and CRC cleared, register cleared.
//   Cmd packet with zero data packets -> err_data.
// TESTING
//   A=0,B=0,op=000, 8 data pkts + cmd payload 8'h0B (crc 1011)
//     -> out_valid 1 cycle, a=0,b=0,op=0, all err 0.
//   Same frame but cmd crc=4'b0000 -> out_valid, err_crc=1, err_data=0, err_op=0.
//   A=32'h0000_0001,B=32'h0000_0002 with only 7 data pkts then cmd -> err_data=1, a=b=0.
//   Valid frame op=3'b111, correct CRC -> err_op=1, err_crc=0, out_op=3'b111.
//   rst pulsed 1 cycle during 5th data packet, then a full valid frame
//     -> no strobe for the aborted frame, exactly one clean strobe after.
//   Stop bit forced 0 on 3rd data packet -> err_data strobe one cycle after that stop bit.
//     Next back-to-back valid frame decodes correctly.

Source files
------------

// File: rtl/mtm_alu_deserializer.sv
// Receive deframer for the ALU serial link: collects A/B data packets and a command
// packet, checks packet count, CRC4 and opcode, and strobes one decoded operation per frame.
module mtm_alu_deserializer #(
   parameter int DATA_PKTS = 8,
   parameter int CRC_W     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sin,
   output logic        out_valid,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [2:0]  out_op,
   output logic        err_data,
   output logic        err_crc,
   output logic        err_op
);

   typedef enum logic [1:0] {IDLE, TYPE, PAYLOAD, STOP} state_t;

   state_t             state, state_nxt;
   logic               is_cmd;
   logic [2:0]         bit_cnt;
   logic [7:0]         payload;
   logic [63:0]        ab;
   logic [3:0]         pkt_cnt;
   logic [CRC_W-1:0]   crc;

   function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic d);
      logic fb;
      fb = c[CRC_W-1] ^ d;
      return {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_W'(3) : '0);
   endfunction

   // The command contributes a constant 1 followed by the opcode to the CRC stream.
   function automatic logic [CRC_W-1:0] crc_cmd(input logic [CRC_W-1:0] c, input logic [2:0] op);
      logic [CRC_W-1:0] r;
      r = crc_step(c, 1'b1);
      for (int i = 2; i >= 0; i--) r = crc_step(r, op[i]);
      return r;
   endfunction

   function automatic logic op_legal(input logic [2:0] op);
      return (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b101);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!sin) state_nxt = TYPE;
         TYPE:    state_nxt = PAYLOAD;
         PAYLOAD: if (bit_cnt == 3'd7) state_nxt = STOP;
         STOP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         is_cmd    <= 1'b0;
         bit_cnt   <= '0;
         payload   <= '0;
         ab        <= '0;
         pkt_cnt   <= '0;
         crc       <= '0;
         out_valid <= 1'b0;
         out_a     <= '0;
         out_b     <= '0;
         out_op    <= '0;
         err_data  <= 1'b0;
         err_crc   <= 1'b0;
         err_op    <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            TYPE: begin
               is_cmd  <= sin;
               bit_cnt <= '0;
            end
            PAYLOAD: begin
               payload <= {payload[6:0], sin};
               bit_cnt <= bit_cnt + 3'd1;
               if (!is_cmd) crc <= crc_step(crc, sin);
            end
            STOP: begin
               if (!sin || is_cmd) begin
                  // Any strobe ends the frame; a bad stop bit reports as a data error.
                  out_valid <= 1'b1;
                  ab        <= '0;
                  pkt_cnt   <= '0;
                  crc       <= '0;
                  if (!sin || (pkt_cnt != 4'(DATA_PKTS))) begin
                     out_a    <= '0;
                     out_b    <= '0;
                     out_op   <= '0;
                     err_data <= 1'b1;
                     err_crc  <= 1'b0;
                     err_op   <= 1'b0;
                  end else begin
                     out_a    <= ab[63:32];
                     out_b    <= ab[31:0];
                     out_op   <= payload[6:4];
                     err_data <= 1'b0;
                     err_crc  <= crc_cmd(crc, payload[6:4]) != payload[CRC_W-1:0];
                     err_op   <= !op_legal(payload[6:4]);
                  end
               end else begin
                  ab <= {ab[55:0], payload};
                  if (pkt_cnt != 4'd15) pkt_cnt <= pkt_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Scoreboard bench for mtm_alu_deserializer: directed frames from the feature list
// followed by randomized frames, checked against a frame-level reference model.
module tb_mtm_alu_deserializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sin = 1'b1;
   logic        out_valid;
   logic [31:0] out_a, out_b;
   logic [2:0]  out_op;
   logic        err_data, err_crc, err_op;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic        ed;
      logic        ec;
      logic        eo;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   mtm_alu_deserializer #(.DATA_PKTS(8), .CRC_W(4)) dut (
      .clk(clk), .rst(rst), .sin(sin),
      .out_valid(out_valid), .out_a(out_a), .out_b(out_b), .out_op(out_op),
      .err_data(err_data), .err_crc(err_crc), .err_op(err_op)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // CRC as the remainder of {A,B,1,op} * x^4 divided by x^4+x+1.
   function automatic logic [3:0] model_crc(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
      logic [71:0] v;
      v = {a, b, 1'b1, op, 4'b0000};
      for (int i = 71; i >= 4; i--)
         if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
      return v[3:0];
   endfunction

   function automatic logic model_op_bad(input logic [2:0] op);
      return !(op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5);
   endfunction

   always @(negedge clk) begin
      if (out_valid) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: got out_valid=1 expected none (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("strobe_cycle", 64'(cyc), 64'(e.cyc));
            check("out_a",    64'(out_a),    64'(e.a));
            check("out_b",    64'(out_b),    64'(e.b));
            check("out_op",   64'(out_op),   64'(e.op));
            check("err_data", 64'(err_data), 64'(e.ed));
            check("err_crc",  64'(err_crc),  64'(e.ec));
            check("err_op",   64'(err_op),   64'(e.eo));
         end
      end
   end

   task automatic send_bit(input logic b);
      sin = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input logic t, input logic [7:0] p, input logic stop);
      send_bit(1'b0);
      send_bit(t);
      for (int i = 7; i >= 0; i--) send_bit(p[i]);
      send_bit(stop);
   endtask

   task automatic push_err_data();
      exp_t e;
      e = '{a: 32'd0, b: 32'd0, op: 3'd0, ed: 1'b1, ec: 1'b0, eo: 1'b0, cyc: cyc};
      sb.push_back(e);
   endtask

   task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input int ndata,
                             input logic [2:0] op, input bit good_crc, input logic [3:0] crc_given,
                             input int bad_pkt, input int gap);
      logic [63:0] ab;
      logic [7:0]  by;
      logic [3:0]  cf;
      exp_t        e;
      ab = {a, b};
      repeat (gap) send_bit(1'b1);
      for (int k = 0; k < ndata; k++) begin
         if (k < 8) by = ab[63 - 8*k -: 8];
         else       by = 8'($urandom);
         send_pkt(1'b0, by, k != bad_pkt);
         if (k == bad_pkt) begin
            push_err_data();
            return;
         end
      end
      cf = good_crc ? model_crc(a, b, op) : crc_given;
      send_pkt(1'b1, {1'($urandom), op, cf}, ndata != bad_pkt);
      if (ndata == bad_pkt || ndata != 8) begin
         push_err_data();
      end else begin
         e = '{a: a, b: b, op: op, ed: 1'b0, ec: (model_crc(a, b, op) != cf),
               eo: model_op_bad(op), cyc: cyc};
         sb.push_back(e);
      end
   endtask

   initial begin
      int r, nd, bp;
      repeat (3) send_bit(1'b1);
      rst = 1'b0;
      check("reset_valid", 64'(out_valid), 64'd0);
      check("reset_a",     64'(out_a),     64'd0);
      check("reset_errs",  64'({err_data, err_crc, err_op}), 64'd0);
      send_bit(1'b1);

      // Directed frames
      send_frame(32'd0, 32'd0, 8, 3'b000, 1'b0, 4'hB, -1, 0);
      send_frame(32'd0, 32'd0, 8, 3'b000, 1'b0, 4'h0, -1, 2);
      send_frame(32'h0000_0001, 32'h0000_0002, 7, 3'b100, 1'b1, 4'h0, -1, 1);
      send_frame(32'hDEAD_BEEF, 32'h1234_5678, 8, 3'b111, 1'b1, 4'h0, -1, 0);
      send_frame(32'h0, 32'h0, 0, 3'b001, 1'b1, 4'h0, -1, 1);

      // Reset in the middle of the 5th data packet of a frame
      send_bit(1'b1);
      for (int k = 0; k < 4; k++) send_pkt(1'b0, 8'hA5, 1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rst = 1'b1;
      send_bit(1'b1);
      rst = 1'b0;
      check("midreset_a",     64'(out_a),    64'd0);
      check("midreset_op",    64'(out_op),   64'd0);
      check("midreset_valid", 64'(out_valid), 64'd0);
      send_frame(32'hCAFE_F00D, 32'h0BAD_C0DE, 8, 3'b101, 1'b1, 4'h0, -1, 2);

      // Framing error on 3rd data packet, then a back-to-back clean frame
      send_frame(32'h1111_2222, 32'h3333_4444, 8, 3'b001, 1'b1, 4'h0, 2, 1);
      send_frame(32'h5555_6666, 32'h7777_8888, 8, 3'b100, 1'b1, 4'h0, -1, 0);

      // Randomized frames
      for (int n = 0; n < 40; n++) begin
         r  = $urandom_range(0, 9);
         nd = (r < 7) ? 8 : $urandom_range(0, 10);
         bp = ($urandom_range(0, 7) == 0) ? $urandom_range(0, nd) : -1;
         send_frame($urandom, $urandom, nd, 3'($urandom), ($urandom_range(0, 3) != 0),
                    4'($urandom), bp, $urandom_range(0, 2));
      end

      for (int w = 0; w < 20 && sb.size() != 0; w++) send_bit(1'b1);
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL strobe_timeout: got %0d pending expected 0", sb.size());
      end
      repeat (3) send_bit(1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
